// File: rtl/vector_alu_seq.sv
// Multi-cycle vector ALU: accepts one operation per handshake, computes
// LANES_PER_CYCLE lanes per clock and holds the full result until it is accepted.
module vector_alu_seq #(
    parameter int NUM_LANES       = 8,
    parameter int ELEM_WIDTH      = 32,
    parameter int LANES_PER_CYCLE = 8,
    parameter int REG_WIDTH       = NUM_LANES * ELEM_WIDTH,
    parameter int NUM_GROUPS      = NUM_LANES / LANES_PER_CYCLE,
    parameter int SHW             = $clog2(ELEM_WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_WIDTH-1:0] A,
    input  logic [REG_WIDTH-1:0] B,
    input  logic                 UseImm,
    input  logic [3:0]           ALUControl,
    input  logic [NUM_LANES-1:0] lane_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_WIDTH-1:0] Result,
    output logic                 Zero
);

    localparam int CW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int GW = LANES_PER_CYCLE * ELEM_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_REPL   = 4'b0010;
    localparam logic [3:0] OP_MUL    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SLT    = 4'b0101;
    localparam logic [3:0] OP_SRL    = 4'b0110;
    localparam logic [3:0] OP_SRA    = 4'b0111;
    localparam logic [3:0] OP_REDSUM = 4'b1000;

    state_t                 state;
    logic [REG_WIDTH-1:0]   a_q, b_q, result_q, result_d;
    logic                   imm_q;
    logic [3:0]             ctrl_q;
    logic [NUM_LANES-1:0]   mask_q;
    logic [CW-1:0]          cnt;
    logic [ELEM_WIDTH-1:0]  acc_q, acc_next, grp_sum;
    logic [GW-1:0]          a_grp, b_grp, grp_vals;
    logic [LANES_PER_CYCLE-1:0] m_grp;
    logic                   last_grp;

    function automatic logic [ELEM_WIDTH-1:0] lane_alu(
        input logic [3:0]            op,
        input logic [ELEM_WIDTH-1:0] a,
        input logic [ELEM_WIDTH-1:0] b
    );
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (op)
            OP_ADD:  lane_alu = a + b;
            OP_SUB:  lane_alu = a - b;
            OP_REPL: lane_alu = b;
            OP_MUL:  lane_alu = a * b;
            OP_SLL:  lane_alu = a << sh;
            OP_SLT:  lane_alu = {{(ELEM_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SRL:  lane_alu = a >> sh;
            OP_SRA:  lane_alu = $signed(a) >>> sh;
            default: lane_alu = '0;
        endcase
    endfunction

    assign in_ready = (state == S_IDLE) && !reset;
    assign Result   = result_q;
    assign Zero     = (result_q == '0);
    assign last_grp = (cnt == CW'(NUM_GROUPS - 1));

    // Bring the current group to the bottom so lane indexing inside it is static.
    assign a_grp = GW'(a_q >> (int'(cnt) * GW));
    assign b_grp = GW'(b_q >> (int'(cnt) * GW));
    assign m_grp = LANES_PER_CYCLE'(mask_q >> (int'(cnt) * LANES_PER_CYCLE));

    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        logic [ELEM_WIDTH-1:0] a_l, opb;
        logic [REG_WIDTH-1:0]  keep;
        grp_vals = '0;
        grp_sum  = '0;
        a_l      = '0;
        opb      = '0;
        for (int j = 0; j < LANES_PER_CYCLE; j++) begin
            a_l = a_grp[j*ELEM_WIDTH +: ELEM_WIDTH];
            opb = imm_q ? b_q[ELEM_WIDTH-1:0] : b_grp[j*ELEM_WIDTH +: ELEM_WIDTH];
            if (ctrl_q == OP_REDSUM) begin
                if (m_grp[j]) grp_sum = grp_sum + a_l;
            end else begin
                grp_vals[j*ELEM_WIDTH +: ELEM_WIDTH] = m_grp[j] ? lane_alu(ctrl_q, a_l, opb) : a_l;
            end
        end
        acc_next = acc_q + grp_sum;
        keep     = ~(REG_WIDTH'({GW{1'b1}}) << (int'(cnt) * GW));
        result_d = (result_q & keep) | (REG_WIDTH'(grp_vals) << (int'(cnt) * GW));
        // Reduction lands in lane 0 only once every group has been accumulated.
        if (ctrl_q == OP_REDSUM && last_grp) result_d[ELEM_WIDTH-1:0] = acc_next;
    end

    // NOTE: the operand latches carry no reset; they are only read after an
    // acceptance has loaded them, so resetting them would buy nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result_q  <= '0;
            cnt       <= '0;
            acc_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of the others, independent of statement order.
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q    <= A;
                        b_q    <= B;
                        imm_q  <= UseImm;
                        ctrl_q <= ALUControl;
                        mask_q <= lane_mask;
                        cnt    <= '0;
                        acc_q  <= '0;
                        state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    result_q <= result_d;
                    acc_q    <= acc_next;
                    cnt      <= cnt + 1'b1;
                    if (last_grp) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/vector_alu_seq.md
Name: vector_alu_seq

Overview:
Parametrised, multi-cycle successor to the combinational vector ALU. It accepts one vector operation through a valid/ready handshake and processes LANES_PER_CYCLE lanes per clock, reusing the lane datapath across groups. It holds the full result until the consumer accepts it. It adds per-lane write masking, a signed compare, right shifts and a cross-lane reduction, and sits between the vector register-file read stage and writeback.

Parameters:
NUM_LANES, 8, number of elements per vector register
ELEM_WIDTH, 32, element width in bits
LANES_PER_CYCLE, 8, lanes computed per clock; must divide NUM_LANES
REG_WIDTH, NUM_LANES*ELEM_WIDTH, derived vector width; do not override
NUM_GROUPS, NUM_LANES/LANES_PER_CYCLE, derived; do not override
SHW, clog2(ELEM_WIDTH), derived shift-amount width

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operation request
in_ready  out  1  block can accept a request
A  in  REG_WIDTH  vector operand A; lane i = A[i*ELEM_WIDTH +: ELEM_WIDTH]
B  in  REG_WIDTH  vector operand B
UseImm  in  1  1: every lane uses B[ELEM_WIDTH-1:0] as operand B
ALUControl  in  4  operation select
lane_mask  in  NUM_LANES  1 = lane written with the computed result
out_valid  out  1  Result is valid
out_ready  in  1  consumer accepts Result
Result  out  REG_WIDTH  operation result
Zero  out  1  Result == 0, qualified by out_valid

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. It overrides everything, including mid-BUSY and DONE; any in-flight operation is discarded with no output.
- Reset values: state IDLE, out_valid=0, Result=0, Zero=1, group counter=0, accumulator=0.
- in_ready = (state==IDLE) and not reset. It is low during BUSY and DONE, so operations never overlap.
- IDLE: on in_valid && in_ready, latch A, B, UseImm, ALUControl and lane_mask; clear counter and accumulator; go to BUSY.
- BUSY: each cycle compute lanes cnt*LANES_PER_CYCLE .. +LANES_PER_CYCLE-1 into the result register, then cnt++. On the cycle with cnt==NUM_GROUPS-1, go to DONE.
- DONE: out_valid=1 and Result/Zero are held stable. On out_ready, go to IDLE and drop out_valid the next cycle.
- Latency: out_valid rises NUM_GROUPS cycles after the acceptance cycle (1 cycle when LANES_PER_CYCLE=NUM_LANES). Next acceptance is possible at the earliest one cycle after the out_valid && out_ready cycle.
- Inputs are sampled only at acceptance; later changes to them are ignored.
- Per lane, OpB = UseImm ? B[ELEM_WIDTH-1:0] : B lane. All arithmetic is modulo 2^ELEM_WIDTH.
- ALUControl encodings:
  - 0000 ADD: A+OpB
  - 0001 SUB: A-OpB
  - 0010 REPL: OpB
  - 0011 MUL: low ELEM_WIDTH bits of the unsigned product
  - 0100 SLL: A << OpB[SHW-1:0]
  - 0101 SLT: 1 if signed A < signed OpB, else 0. This is a true signed compare, overflow-correct.
  - 0110 SRL: logical A >> OpB[SHW-1:0]
  - 0111 SRA: arithmetic A >>> OpB[SHW-1:0]
  - 1000 REDSUM: lane 0 = sum of A over all lanes with mask=1 (OpB ignored); lanes 1..N-1 = 0. The accumulator is built across groups, and lane 0 is written in the final BUSY cycle.
  - Any other encoding: result 0 in every lane.
- Masking (non-REDSUM ops): lanes with mask=0 output the latched A lane unchanged (merge semantics). For REDSUM, masked lanes are excluded from the sum and lane 0 is written regardless of mask[0]. If the mask is all zero, REDSUM lane 0 = 0.
- Zero is computed from the final registered Result.

Test Plan:
- Defaults; ADD; A lanes = i, B lanes = 10, mask=FF, out_ready=1 -> out_valid 1 cycle after acceptance; lanes = 10+i; Zero=0.
- SLT; A lane0=0x80000000, B lane0=0x7FFFFFFF (overflow case); SUB lane1 5-7 -> lane0=1, and SUB lane1=0xFFFFFFFE.
- LANES_PER_CYCLE=2; MUL with UseImm, B[31:0]=3, A lanes = i+1 -> out_valid exactly 4 cycles after acceptance; lanes = 3(i+1); in_ready low throughout BUSY and DONE.
- REDSUM; A lanes = 0xFFFFFFFF,1,2..7, mask=0xFE -> lane0=28, other lanes 0. Then mask=0 -> Result=0, Zero=1.
- Mask merge on SRA; A=0xF0000000 all lanes, shift 4, mask=0x0F -> lanes 0-3 = 0xFF000000, lanes 4-7 = 0xF0000000.
- out_ready held low 5 cycles -> Result stable, in_ready=0. Separately, reset asserted mid-BUSY -> next cycle out_valid=0, Result=0, in_ready=1 after reset deasserts, and no stale output appears.
